uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the single-byte receiver. It adds:
- configurable data width
- runtime parity and stop-bit modes
- 3-sample majority voting
- break detection
- an output FIFO with valid/ready handshake and per-entry error status

It sits between the rx_pin pad and the peripheral's register/bus interface.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first on the line
FIFO_DEPTH, 8, receive FIFO entries, power of two, >=2
DIV_W, 16, width of baud_div

Ports:
clk  input  1  system clock
rst_n  input  1  reset
baud_div  input  DIV_W  clocks per bit; legal range >=8
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  1 = two stop bits, 0 = one
rx_pin  input  1  serial line, idle high, asynchronous to clk
m_data  output  DATA_BITS  FIFO head data
m_status  output  3  FIFO head {break, frame_err, parity_err}
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts head when m_valid&&m_ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
rx_busy  output  1  frame in progress (state != IDLE)
overrun  output  1  sticky: frame dropped because FIFO full
clr_overrun  input  1  single-cycle pulse clears overrun

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low clears all state immediately, including mid-frame.
- Reset values: m_valid=0, fifo_level=0, rx_busy=0, overrun=0, m_data=0, m_status=0, synchronizer flops=1, FSM=IDLE.
- Input synchronisation: rx_pin goes through a 2-flop synchronizer, giving rxs. All decisions use rxs.
- Config latching: baud_div, cfg_parity and cfg_stop2 are latched on the IDLE->START transition. Changes mid-frame have no effect.
- Bit timer: counter loads baud_div-1 at the start of each bit and counts down to 0; the bit ends at 0.
  - Let h = baud_div>>1. rxs is sampled when cnt == h+1, h and h-1.
  - The bit value is the majority of the 3 samples, evaluated at cnt==0.
- FSM states:
  - IDLE: rxs==0 -> START, load counter.
  - START: at cnt==0, majority 1 -> IDLE (false start, nothing pushed); else -> DATA, bit index 0.
  - DATA: at cnt==0, shift the voted bit in at the MSB (LSB-first line order). After bit DATA_BITS-1 -> PARITY if parity enabled, else STOP1.
  - PARITY: voted bit is checked.
    - Even mode: popcount(data)+parity must be even.
    - Odd mode: the sum must be odd.
    - Mismatch sets parity_err.
    - -> STOP1.
  - STOP1: voted 0 sets frame_err. -> STOP2 if cfg_stop2, else PUSH.
  - STOP2: voted 0 sets frame_err. -> PUSH.
  - PUSH (1 cycle): write {status,data} to the FIFO if not full; if full, drop the frame and set overrun.
    - break = all data bits 0 AND parity bit (if any) 0 AND STOP1 bit 0; frame_err is also 1.
    - -> WAIT_HIGH if break, else IDLE.
  - WAIT_HIGH: stay until rxs==1 for one sample, then -> IDLE. Prevents a held-low line generating repeated frames.
- FIFO:
  - Registered head. m_valid asserts the cycle after PUSH writes into an empty FIFO.
  - Pop on m_valid&&m_ready.
  - Push and pop in the same cycle: level unchanged; push is accepted even when full because a pop frees a slot.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun:
  - Set on a drop; held until a clr_overrun pulse.
  - If a set and a clear occur in the same cycle, set wins.
- Latency: the frame entry is visible (m_valid) 2 cycles after the end of the last stop bit period.

Test Plan:
1. baud_div=16, parity none, 1 stop, send 0xA5 -> one entry: m_data=0xA5, m_status=000, rx_busy returns 0, fifo_level=1.
2. Even parity, send 0x03 with parity bit 1 -> m_status=001. Resend with parity bit 0 -> m_status=000. Repeat in odd mode -> results inverted.
3. cfg_stop2=1, send 0x5A with second stop bit 0 -> m_status=010. Line held low for 2 frame times -> exactly one entry, m_data=0x00, m_status=110, no further entries until line high then a new start.
4. FIFO_DEPTH=4, m_ready=0, send 5 frames 0x01..0x05 -> fifo_level=4, overrun=1, head 0x01. Drain gives 0x01..0x04. clr_overrun -> overrun=0. Simultaneous push/pop at full keeps level 4.
5. Low glitch of 3 clocks on idle line, and a single-clock glitch on one data-bit mid-sample -> no entry for the false start; majority vote yields the correct byte.
6. Assert rst_n low mid-DATA bit 4 -> all outputs at reset values immediately. After release, a clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with 3-sample majority voting, runtime parity/stop modes,
// break detection and a status-tagged receive FIFO with valid/ready output.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_stop2,
   input  logic                        rx_pin,
   output logic [DATA_BITS-1:0]        m_data,
   output logic [2:0]                  m_status,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        rx_busy,
   output logic                        overrun,
   input  logic                        clr_overrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS);
   localparam int EW = DATA_BITS + 3;
   localparam logic [DIV_W-1:0] ONE = 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH, WAIT_HIGH} state_t;

   state_t               state_q, state_d;
   logic                 sync_q, sync_d, rxs_q, rxs_d;
   logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d, h;
   logic [1:0]           par_q, par_d;
   logic                 stop2_q, stop2_d;
   logic [2:0]           smp_q, smp_d;
   logic [BW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d, s1_q, s1_d;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [EW-1:0]        mem_d [FIFO_DEPTH];
   logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]          lvl_q, lvl_d;
   logic                 ovr_q, ovr_d;
   logic                 vote, bit_end, par_en, brk, push, pop, full, wr_ok, drop;

   always_comb begin
      sync_d  = rx_pin;
      rxs_d   = sync_q;
      state_d = state_q;
      div_d   = div_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      cnt_d   = cnt_q;
      smp_d   = smp_q;
      idx_d   = idx_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      pbit_d  = pbit_q;
      s1_d    = s1_q;
      push    = 1'b0;
      h       = div_q >> 1;
      bit_end = cnt_q == '0;
      vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
      par_en  = par_q == 2'b01 || par_q == 2'b10;
      brk     = data_q == '0 && !(par_en && pbit_q) && !s1_q;
      // bit-timed states share one reload-on-zero counter and a mid-bit sample window
      if (state_q != IDLE && state_q != PUSH && state_q != WAIT_HIGH) begin
         cnt_d = bit_end ? div_q - ONE : cnt_q - ONE;
         if (cnt_q == h + ONE || cnt_q == h || cnt_q == h - ONE)
            smp_d = {smp_q[1:0], rxs_q};
      end
      case (state_q)
         IDLE: if (!rxs_q) begin
            state_d = START;
            div_d   = baud_div;
            par_d   = cfg_parity;
            stop2_d = cfg_stop2;
            cnt_d   = baud_div - ONE;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
         end
         START: if (bit_end) begin
            state_d = vote ? IDLE : DATA;
            idx_d   = '0;
         end
         DATA: if (bit_end) begin
            data_d = {vote, data_q[DATA_BITS-1:1]};
            idx_d  = idx_q + BW'(1);
            if (idx_q == BW'(DATA_BITS - 1))
               state_d = par_en ? PARITY : STOP1;
         end
         PARITY: if (bit_end) begin
            pbit_d  = vote;
            perr_d  = ^data_q ^ vote ^ par_q[1];
            state_d = STOP1;
         end
         STOP1: if (bit_end) begin
            s1_d    = vote;
            ferr_d  = !vote;
            state_d = stop2_q ? STOP2 : PUSH;
         end
         STOP2: if (bit_end) begin
            ferr_d  = ferr_q | !vote;
            state_d = PUSH;
         end
         PUSH: begin
            push    = 1'b1;
            state_d = brk ? WAIT_HIGH : IDLE;
         end
         WAIT_HIGH: if (rxs_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   always_comb begin
      pop   = m_valid && m_ready;
      full  = lvl_q == (AW+1)'(FIFO_DEPTH);
      wr_ok = push && (!full || pop);
      drop  = push && full && !pop;
      mem_d = mem_q;
      if (wr_ok) mem_d[wr_q] = {brk, ferr_q, perr_q, data_q};
      wr_d  = wr_q + AW'(wr_ok);
      rd_d  = rd_q + AW'(pop);
      lvl_d = lvl_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
      ovr_d = drop ? 1'b1 : clr_overrun ? 1'b0 : ovr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync_q  <= 1'b1;
         rxs_q   <= 1'b1;
         div_q   <= '0;
         par_q   <= '0;
         stop2_q <= 1'b0;
         cnt_q   <= '0;
         smp_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         pbit_q  <= 1'b0;
         s1_q    <= 1'b0;
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         lvl_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         rxs_q   <= rxs_d;
         div_q   <= div_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         cnt_q   <= cnt_d;
         smp_q   <= smp_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         pbit_q  <= pbit_d;
         s1_q    <= s1_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         lvl_q   <= lvl_d;
         ovr_q   <= ovr_d;
      end
   end

   assign {m_status, m_data} = mem_q[rd_q];
   assign m_valid    = lvl_q != '0;
   assign fifo_level = lvl_q;
   assign rx_busy    = state_q != IDLE;
   assign overrun    = ovr_q;
endmodule
